// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU) that sits next
//   to the single-cycle integer datapath. A request is taken through a
//   valid/ready handshake, the quotient is produced one bit per cycle by a
//   radix-2 restoring shift-subtract loop, and the result is handed back
//   through a second valid/ready handshake. A flush aborts any operation.
//
// Ports
//   clk_i       in   1     clock, rising edge
//   rst_ni      in   1     asynchronous active-low reset
//   valid_i     in   1     request valid
//   ready_o     out  1     unit can accept a request (IDLE only)
//   op_i        in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i  in   XLEN  rs1 value
//   divisor_i   in   XLEN  rs2 value
//   valid_o     out  1     result valid (DONE only)
//   ready_i     in   1     consumer accepts the result
//   result_o    out  XLEN  quotient or remainder, 0 while valid_o is low
//   busy_o      out  1     operation in flight or result pending
//   flush_i     in   1     synchronous abort, highest priority
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o,
  input  logic            flush_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [4:0]      CNT_INIT = 5'd31;

  // Two's complement negation when en is set. The magnitude of the most
  // negative value comes out as 2^31, which is exactly what the unsigned
  // loop needs.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                               input logic            en);
    logic [XLEN-1:0] r;
    if (en) begin
      r = ~v + XLEN'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Architectural state
  state_e          state_q, state_d;
  logic            rem_op_q, rem_op_d;   // 1: REM/REMU, 0: DIV/DIVU
  logic            neg_quo_q, neg_quo_d; // quotient needs negation
  logic            neg_rem_q, neg_rem_d; // remainder needs negation
  logic [XLEN-1:0] rem_q, rem_d;         // partial remainder (always < divisor)
  logic [XLEN-1:0] quo_q, quo_d;         // quotient shift register
  logic [XLEN-1:0] dvd_q, dvd_d;         // dividend shift register
  logic [XLEN-1:0] dsr_q, dsr_d;         // divisor magnitude
  logic [4:0]      cnt_q, cnt_d;         // iterations remaining minus one

  // Request decode
  logic            signed_op_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic [XLEN-1:0] a_mag_s;
  logic [XLEN-1:0] b_mag_s;
  logic            div_zero_s;
  logic            overflow_s;

  // Iteration datapath
  logic [XLEN:0]   rem_shift_s;
  logic [XLEN:0]   diff_s;
  logic            q_bit_s;
  logic [XLEN-1:0] rem_next_s;
  logic [XLEN-1:0] quo_next_s;

  // Decode the incoming request: sign flags, magnitudes and special cases.
  always_comb begin
    signed_op_s = ~op_i[0];
    a_neg_s     = signed_op_s & dividend_i[XLEN-1];
    b_neg_s     = signed_op_s & divisor_i[XLEN-1];
    a_mag_s     = cond_neg(dividend_i, a_neg_s);
    b_mag_s     = cond_neg(divisor_i, b_neg_s);
    div_zero_s  = (divisor_i == ZERO);
    overflow_s  = signed_op_s & (dividend_i == MIN_NEG) & (divisor_i == ALL_ONES);
  end

  // One restoring step. The shifted remainder is at most 2*divisor-1, so a
  // non-negative difference always fits below bit XLEN and the MSB of the
  // difference is a clean borrow flag: 0 means rem' >= divisor.
  always_comb begin
    rem_shift_s = {rem_q, dvd_q[XLEN-1]};
    diff_s      = rem_shift_s - {1'b0, dsr_q};
    q_bit_s     = ~diff_s[XLEN];
    if (q_bit_s) begin
      rem_next_s = diff_s[XLEN-1:0];
    end else begin
      rem_next_s = rem_shift_s[XLEN-1:0];
    end
    quo_next_s = {quo_q[XLEN-2:0], q_bit_s};
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    rem_op_d  = rem_op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (flush_i) begin
          // A request arriving together with a flush is dropped.
          state_d = IDLE;
        end else if (valid_i) begin
          rem_op_d = op_i[1];
          dvd_d    = a_mag_s;
          dsr_d    = b_mag_s;
          cnt_d    = CNT_INIT;
          if (div_zero_s || overflow_s) begin
            // Final values go straight into quo/rem with fixup disabled, so
            // the DONE output path is shared with the normal case.
            state_d   = DONE;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            if (div_zero_s) begin
              quo_d = ALL_ONES;
              rem_d = dividend_i;
            end else begin
              quo_d = MIN_NEG;
              rem_d = ZERO;
            end
          end else begin
            state_d   = BUSY;
            neg_quo_d = a_neg_s ^ b_neg_s;
            neg_rem_d = a_neg_s;
            quo_d     = ZERO;
            rem_d     = ZERO;
          end
        end else begin
          state_d = IDLE;
        end
      end

      BUSY: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_next_s;
          quo_d = quo_next_s;
          dvd_d = {dvd_q[XLEN-2:0], 1'b0};
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end

      DONE: begin
        // Flush wins over the handshake: the result counts as discarded.
        if (flush_i) begin
          state_d = IDLE;
        end else if (ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rem_op_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_q     <= ZERO;
      quo_q     <= ZERO;
      dvd_q     <= ZERO;
      dsr_q     <= ZERO;
      cnt_q     <= 5'd0;
    end else begin
      state_q   <= state_d;
      rem_op_q  <= rem_op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Handshake outputs come from the state register alone; the result is the
  // sign-fixed quotient/remainder, held stable in DONE because no register
  // changes there.
  always_comb begin
    ready_o = (state_q == IDLE);
    valid_o = (state_q == DONE);
    busy_o  = (state_q == BUSY) || (state_q == DONE);
    if (state_q == DONE) begin
      if (rem_op_q) begin
        result_o = cond_neg(rem_q, neg_rem_q);
      end else begin
        result_o = cond_neg(quo_q, neg_quo_q);
      end
    end else begin
      result_o = ZERO;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        busy_o;
  logic        flush_i;

  int checks = 0;
  int errors = 0;

  div_unit #(.XLEN(32)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o),
    .busy_o     (busy_o),
    .flush_i    (flush_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference: RISC-V M semantics with plain integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'b00: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
      2'b01: return a / b;
      2'b10: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0) return 0;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request and return #1 after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("issue_ready", {31'd0, ready_o}, 32'd1);
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    valid_i    = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i    = 1'b0;
    // Garbage on the operand bus must not disturb the running operation.
    op_i       = 2'($urandom_range(3));
    dividend_i = $urandom;
    divisor_i  = $urandom;
  endtask

  // Number of edges after the accepting edge until valid_o is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid_o && lat < 40) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
  endtask

  task automatic run_check(input string tag, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    int lat;
    issue(op, a, b);
    wait_valid(lat);
    check({tag, "_lat"}, 32'(lat), 32'(ref_latency(op, a, b)));
    check({tag, "_res"}, result_o, ref_result(op, a, b));
    @(posedge clk_i);
    #1;
    check({tag, "_idle"}, {30'd0, ready_o, valid_o}, 32'd2);
  endtask

  initial begin
    logic [1:0]  t_op [14];
    logic [31:0] t_a  [14];
    logic [31:0] t_b  [14];
    int          lat;
    logic        seen;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
    op_i = 2'd0; dividend_i = 32'd0; divisor_i = 32'd0;
    #12;
    check("rst_outs", {28'd0, ready_o, valid_o, busy_o, 1'b0}, 32'd8);
    check("rst_result", result_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed operations from the test plan
    t_op[0]  = 2'b01; t_a[0]  = 32'd100;        t_b[0]  = 32'd7;
    t_op[1]  = 2'b11; t_a[1]  = 32'd100;        t_b[1]  = 32'd7;
    t_op[2]  = 2'b01; t_a[2]  = 32'hFFFF_FFFF;  t_b[2]  = 32'd1;
    t_op[3]  = 2'b00; t_a[3]  = 32'hFFFF_FFF9;  t_b[3]  = 32'd2;
    t_op[4]  = 2'b10; t_a[4]  = 32'hFFFF_FFF9;  t_b[4]  = 32'd2;
    t_op[5]  = 2'b00; t_a[5]  = 32'd7;          t_b[5]  = 32'hFFFF_FFFE;
    t_op[6]  = 2'b10; t_a[6]  = 32'd7;          t_b[6]  = 32'hFFFF_FFFE;
    t_op[7]  = 2'b00; t_a[7]  = 32'h8000_0000;  t_b[7]  = 32'd2;
    t_op[8]  = 2'b00; t_a[8]  = 32'd5;          t_b[8]  = 32'd0;
    t_op[9]  = 2'b10; t_a[9]  = 32'd5;          t_b[9]  = 32'd0;
    t_op[10] = 2'b11; t_a[10] = 32'h8000_0000;  t_b[10] = 32'd0;
    t_op[11] = 2'b00; t_a[11] = 32'h8000_0000;  t_b[11] = 32'hFFFF_FFFF;
    t_op[12] = 2'b10; t_a[12] = 32'h8000_0000;  t_b[12] = 32'hFFFF_FFFF;
    t_op[13] = 2'b01; t_a[13] = 32'h8000_0000;  t_b[13] = 32'hFFFF_FFFF;
    for (int i = 0; i < 14; i++) begin
      run_check($sformatf("dir%0d", i), t_op[i], t_a[i], t_b[i]);
    end

    // Backpressure: hold the result for 5 cycles
    ready_i = 1'b0;
    issue(2'b00, 32'hFFFF_FFF9, 32'd2);
    wait_valid(lat);
    check("bp_lat", 32'(lat), 32'd32);
    check("bp_res", result_o, 32'hFFFF_FFFD);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      check("bp_hold_res", result_o, 32'hFFFF_FFFD);
      check("bp_hold_flags", {29'd0, valid_o, ready_o, busy_o}, 32'd5);
    end
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("bp_release", {29'd0, valid_o, ready_o, busy_o}, 32'd2);
    run_check("bp_next", 2'b10, 32'd7, 32'hFFFF_FFFE);

    // Flush in the 10th BUSY cycle
    issue(2'b01, 32'd1000, 32'd3);
    repeat (9) @(posedge clk_i);
    #1;
    check("fl_busy", {31'd0, busy_o}, 32'd1);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    check("fl_idle", {29'd0, valid_o, ready_o, busy_o}, 32'd2);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i);
      #1;
      if (valid_o) seen = 1'b1;
    end
    check("fl_no_valid", {31'd0, seen}, 32'd0);

    // Flush together with a request in IDLE drops the request
    @(negedge clk_i);
    valid_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; dividend_i = 32'd8; divisor_i = 32'd0;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0; flush_i = 1'b0;
    check("fl_idle_drop", {29'd0, valid_o, ready_o, busy_o}, 32'd2);

    // Flush together with ready_i in DONE discards the result
    ready_i = 1'b0;
    issue(2'b00, 32'd5, 32'd0);
    check("fl_done_valid", {31'd0, valid_o}, 32'd1);
    flush_i = 1'b1; ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    check("fl_done_idle", {29'd0, valid_o, ready_o, busy_o}, 32'd2);

    // Asynchronous reset mid-BUSY
    issue(2'b01, 32'd12345, 32'd7);
    repeat (5) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_outs", {29'd0, valid_o, ready_o, busy_o}, 32'd2);
    check("arst_result", result_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_check("post_rst", 2'b01, 32'd9, 32'd3);

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(1000)); rb = 32'($urandom_range(1, 20)); end
        3: rb = {28'hFFF_FFFF, 4'($urandom_range(15))};
        default: ;
      endcase
      run_check($sformatf("rnd%0d", i), rop, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
